puf_crp_logger: RTL
===================

# puf_crp_logger

Downstream consumer of the 8-bit ring-oscillator PUF response stage. It captures each completed challenge-response pair (CRP) when the PUF signals completion, buffers pairs in a small FIFO, and streams them off-chip as two 8N1 UART bytes per pair. Characterisation scripts on the host use this stream to collect CRPs across boards.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal ≥ 4.
- DEPTH, 16, FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- challenge  in  6  current PUF challenge (switch value).
- response  in  8  PUF response; valid while done=1.
- done  in  1  PUF completion level, combinational from the PUF FSM.
- tx  out  1  UART serial out; idle high.
- busy  out  1  high while a frame is being serialised.
- fifo_full  out  1  FIFO holds DEPTH entries.
- drop_cnt  out  8  CRPs lost to a full FIFO; saturates at 255.

## Operation
- Edge detect: done_d is done registered. capture = done & ~done_d. Only the rising edge captures, so a long done level yields exactly one CRP. A new rise happens only after the PUF recalculates.
- On capture, {challenge, response} is sampled in the same cycle and pushed if the FIFO is not full.
- If capture occurs while full and no pop occurs that cycle: drop the CRP and increment drop_cnt, saturating at 255. If a pop occurs in the same cycle, the push is accepted.
- FIFO: DEPTH entries of 14 bits. Pointers carry one extra wrap bit. Full means pointers are equal except the wrap bit; empty means pointers are fully equal. No overflow or underflow corruption is allowed.
- TX FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START with byte index 0.
  - START: drive tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: drive 8 bits LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: drive tx=1 for CLKS_PER_BIT cycles. If index is 0, load byte 1 and go to START; otherwise go to IDLE.
- Byte 0 = {2'b10, challenge}. Byte 1 = response.
- busy is high in START, DATA and STOP.
- Pairs that are queued back to back are sent with no idle gap beyond one IDLE cycle.

## Timing
- Reset values: tx=1, busy=0, fifo_full=0, drop_cnt=0, FIFO empty, FSM in IDLE, done_d=0.
- Reset mid-frame aborts the frame. tx is 1 in the cycle after rst is sampled high, and queued entries are discarded.
- Capture latency: a rise on done seen at edge N writes the FIFO at edge N+1.
  - With the FSM idle, IDLE pops at edge N+2.
  - tx falls, and busy rises, after edge N+2.
- Frame length: 20·CLKS_PER_BIT cycles per CRP.
- fifo_full and drop_cnt update registered, one cycle after the causing event.
- challenge and response are assumed static around the done edge. No internal synchroniser is needed: all inputs are in the clk domain.

## Structure
- Package puf_pkg:
  - CHAL_W=6, RESP_W=8.
  - typedef crp_t packed struct {challenge, response}.
  - CRP_TAG=2'b10.
  - enum tx_state_t {IDLE, START, DATA, STOP}.
- Sub-module uart_tx_byte: baud counter, bit index, shift register and start/stop framing.
  - Load/ready handshake: load is accepted only when ready=1.
  - ready returns high in the cycle after the stop bit completes.
- The top level holds the edge detect, FIFO, drop counter and pair sequencer.

## Test plan
Run with CLKS_PER_BIT=4, DEPTH=4.
- Basic pair: challenge=6'h2A, response=8'hC3, done rises and stays high 200 cycles → exactly one frame on tx: bytes 8'hAA then 8'hC3, 8N1, LSB first; busy high 80 cycles.
- Level vs edge: done toggles 0→1→0→1 with responses 8'h01 and 8'h02 → two CRPs transmitted in order; holding done high produces no extra frame.
- Overflow: 7 captures spaced 3 cycles apart, FSM busy → first 5 accepted (1 in flight + 4 queued), drop_cnt=2, fifo_full=1 until the second pop; all 5 frames emerge in order.
- Simultaneous push/pop at full: capture on the exact cycle IDLE pops → push accepted, drop_cnt unchanged.
- Saturation: force 300 drops → drop_cnt=255 and holds.
- Reset mid-frame: assert rst during DATA bit 3 of byte 0 → tx=1, busy=0 next cycle; FIFO empty; no further frames until a new capture.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared types and constants for the PUF challenge-response logger.
package puf_pkg;

    localparam int CHAL_W = 6;
    localparam int RESP_W = 8;

    // Marks byte 0 of a pair so the host can resynchronise on the stream.
    localparam logic [1:0] CRP_TAG = 2'b10;

    typedef struct packed {
        logic [CHAL_W-1:0] challenge;
        logic [RESP_W-1:0] response;
    } crp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // First byte on the wire: tag in the top bits, challenge below.
    function automatic logic [7:0] crp_byte0(input crp_t c);
        return {CRP_TAG, c.challenge};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serialiser for one CRP: byte 0 then byte 1, back to back with no gap.
// A load is taken only while ready is high (IDLE). ready comes back in the
// cycle after the second stop bit completes.
module uart_tx_byte
    import puf_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ready,
    output logic       busy,
    output logic       tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_t         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              byte_q, byte_d;
    logic [7:0]        shreg_q, shreg_d;
    logic [7:0]        hold_q, hold_d;
    logic              tx_q, tx_d;
    logic              baud_end;

    assign baud_end = (baud_q == BAUD_LAST);
    assign ready    = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx       = tx_q;

    // Framing FSM; tx is registered from the value the next state will drive.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = data0;
                    hold_d  = data1;
                    byte_d  = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!byte_q) begin
                        shreg_d = hold_q;
                        byte_d  = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // State register; reset aborts any frame and parks the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= 1'b0;
            shreg_q <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/puf_crp_logger.sv
// Captures one CRP per rising edge of done, queues it, and streams each
// pair off-chip as two UART bytes. Overflowing captures are counted.
module puf_crp_logger
    import puf_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] challenge,
    input  logic [7:0] response,
    input  logic       done,
    output logic       tx,
    output logic       busy,
    output logic       fifo_full,
    output logic [7:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic          done_dly_q, done_dly_d;
    logic          cap_q, cap_d;
    crp_t          cap_crp_q, cap_crp_d;
    crp_t          mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          capture, empty, full, pop, push, drop, ready;
    crp_t          head;

    assign capture   = done & ~done_dly_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign pop       = ready & ~empty;
    // A pop in the same cycle frees the slot being written, so accept then.
    assign push      = cap_q & (~full | pop);
    assign drop      = cap_q & full & ~pop;
    assign fifo_full = full;
    assign drop_cnt  = drop_cnt_q;

    // Edge detect, capture register, FIFO pointers and saturating drop count.
    always_comb begin
        done_dly_d = done;
        cap_d      = capture;
        cap_crp_d  = cap_crp_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        drop_cnt_d = drop_cnt_q;
        if (capture) begin
            cap_crp_d.challenge = challenge;
            cap_crp_d.response  = response;
        end
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // Control registers; reset empties the queue and clears the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_dly_q <= 1'b0;
            cap_q      <= 1'b0;
            cap_crp_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            done_dly_q <= done_dly_d;
            cap_q      <= cap_d;
            cap_crp_q  <= cap_crp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate reads.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cap_crp_q;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk   (clk),
        .rst   (rst),
        .load  (pop),
        .data0 (crp_byte0(head)),
        .data1 (head.response),
        .ready (ready),
        .busy  (busy),
        .tx    (tx)
    );

endmodule
